// File: rtl/store_pkg.sv
// Shared definitions for the store path.
//   SB / SH / SW : funct3 encodings of the supported store widths
//   st_entry_t   : one buffered store {word address, lane-aligned data, byte strobes}
package store_pkg;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  strb;
    } st_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational store aligner: replicates the significant low bytes of rs2
// across the word, builds byte strobes from the address offset and flags
// misaligned or unsupported stores.
//   funct3 : store width (SB/SH/SW)
//   addr   : byte address of the store
//   rs2    : unaligned store data
//   entry  : aligned {waddr, data, strb}
//   err    : misaligned access or illegal funct3
module store_align
    import store_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2,
    output st_entry_t   entry,
    output logic        err
);

    logic [1:0] off;
    assign off = addr[1:0];

    always_comb begin
        entry.waddr = addr[31:2];
        entry.data  = rs2;
        entry.strb  = 4'b0000;
        err         = 1'b0;
        case (funct3)
            SB: begin
                entry.data = {4{rs2[7:0]}};
                entry.strb = 4'b0001 << off;
            end
            SH: begin
                entry.data = {2{rs2[15:0]}};
                entry.strb = 4'b0011 << off;
                err        = off[0];
            end
            SW: begin
                entry.strb = 4'b1111;
                err        = (off != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between execute and the data-memory write master.
// Aligned stores are queued in a DEPTH-entry FIFO and drained over a
// valid/ready handshake; pending entries are compared against the load
// word address so the pipeline can stall a conflicting load.
//   clk, rst                 : clock, synchronous active-high reset
//   i_st_valid / o_st_ready  : store request handshake (ready = !full)
//   i_funct3, i_ALUout, i_rs2: store width, byte address, data
//   o_st_err                 : current request misaligned / illegal (dropped)
//   o_DM_valid / i_DM_ready  : head entry handshake toward memory
//   o_DM_addr, o_DM_DO, o_DM_WSTRB : head entry word address, data, strobes
//   i_ld_addr / o_ld_hazard  : load address and overlap with any pending store
//   o_empty                  : no pending stores
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_st_valid,
    output logic        o_st_ready,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_ALUout,
    input  logic [31:0] i_rs2,
    output logic        o_st_err,
    output logic        o_DM_valid,
    input  logic        i_DM_ready,
    output logic [31:0] o_DM_addr,
    output logic [31:0] o_DM_DO,
    output logic [3:0]  o_DM_WSTRB,
    input  logic [31:0] i_ld_addr,
    output logic        o_ld_hazard,
    output logic        o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    st_entry_t     al_entry;
    logic          al_err;
    st_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [AW-1:0] slot;
    logic          full;
    logic          empty;
    logic          enq;
    logic          deq;
    logic          unused_ld_off;

    store_align u_align (
        .funct3 (i_funct3),
        .addr   (i_ALUout),
        .rs2    (i_rs2),
        .entry  (al_entry),
        .err    (al_err)
    );

    // Extra pointer MSB distinguishes full from empty when the slot bits match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    assign o_st_ready = !full;
    assign o_st_err   = i_st_valid && al_err;
    assign o_empty    = empty;
    assign o_DM_valid = !empty;

    // Readiness depends only on registered fullness, so a dequeue in the same
    // cycle never lets a store slip into a full buffer.
    assign enq = i_st_valid && o_st_ready && !al_err;
    assign deq = o_DM_valid && i_DM_ready;

    assign o_DM_addr  = {mem[rd_ptr[AW-1:0]].waddr, 2'b00};
    assign o_DM_DO    = mem[rd_ptr[AW-1:0]].data;
    assign o_DM_WSTRB = mem[rd_ptr[AW-1:0]].strb;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (enq) begin
                mem[wr_ptr[AW-1:0]] <= al_entry;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Walk occupied slots starting at the head; the head stays covered until
    // its handshake completes.
    always_comb begin
        o_ld_hazard = 1'b0;
        slot        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr[AW-1:0] + AW'(k);
            if ((PW'(k) < count) && (mem[slot].waddr == i_ld_addr[31:2])) begin
                o_ld_hazard = 1'b1;
            end
        end
    end

    assign unused_ld_off = &{1'b0, i_ld_addr[1:0]};

endmodule
